// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard (interlock/forwarding) logic.
//   REGAW_DEF   default register address width (MIPS: 32 registers)
//   FWD_RF      forward select value meaning "read the register file"
//   STG_*       scoreboard stage numbers as seen by the forward selects
//   sb_entry_t  one scoreboard entry {wreg, m2reg, rn} at the default width
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REGAW_DEF = 5;

  localparam int FWD_RF  = 0;
  localparam int STG_EXE = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  typedef struct packed {
    logic                 wreg;
    logic                 m2reg;
    logic [REGAW_DEF-1:0] rn;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_if
// Bundle between the ID stage and the hazard unit.
//   ID -> unit : id_valid, id_src, id_use, id_wreg, id_rn, id_m2reg, flush
//   unit -> ID : fwd (per-operand select), nostall, trk_wreg, trk_rn
// master = ID/control side, slave = hazard unit.
// ---------------------------------------------------------------------------
interface pipe_hazard_unit_if #(
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int REGAW   = pipe_pkg::REGAW_DEF
);

  logic                                   id_valid;
  logic [NSRC*REGAW-1:0]                  id_src;
  logic [NSRC-1:0]                        id_use;
  logic                                   id_wreg;
  logic [REGAW-1:0]                       id_rn;
  logic                                   id_m2reg;
  logic                                   flush;
  logic [NSRC*$clog2(NSTAGES+1)-1:0]      fwd;
  logic                                   nostall;
  logic [NSTAGES-1:0]                     trk_wreg;
  logic [NSTAGES*REGAW-1:0]               trk_rn;

  modport master (
    output id_valid, id_src, id_use, id_wreg, id_rn, id_m2reg, flush,
    input  fwd, nostall, trk_wreg, trk_rn
  );

  modport slave (
    input  id_valid, id_src, id_use, id_wreg, id_rn, id_m2reg, flush,
    output fwd, nostall, trk_wreg, trk_rn
  );

endinterface

// File: rtl/pipe_fwd_match.sv
// ---------------------------------------------------------------------------
// pipe_fwd_match
// Priority matcher for one source operand against the scoreboard.
//   src, src_used      operand register number and "actually read" flag
//   wreg, m2reg, rn    flattened scoreboard, bit/field k-1 = stage k
//   fwd                0 = register file, k = youngest stage holding src
//   hazard             youngest producer is a load whose data is not yet
//                      available (stage < LOAD_LAT)
// ---------------------------------------------------------------------------
module pipe_fwd_match #(
  parameter int NSTAGES  = 3,
  parameter int REGAW    = pipe_pkg::REGAW_DEF,
  parameter int LOAD_LAT = 2,
  parameter int FW       = $clog2(NSTAGES+1)
) (
  input  logic [REGAW-1:0]         src,
  input  logic                     src_used,
  input  logic [NSTAGES-1:0]       wreg,
  input  logic [NSTAGES-1:0]       m2reg,
  input  logic [NSTAGES*REGAW-1:0] rn,
  output logic [FW-1:0]            fwd,
  output logic                     hazard
);

  import pipe_pkg::*;

  // Walk from the oldest stage towards EXE so a younger match overwrites an
  // older one; the last write therefore belongs to the youngest producer.
  always_comb begin
    fwd    = FW'(FWD_RF);
    hazard = 1'b0;
    if (src_used && (src != '0)) begin
      for (int k = NSTAGES; k >= 1; k--) begin
        if (wreg[k-1] && (rn[(k-1)*REGAW +: REGAW] == src)) begin
          fwd    = FW'(k);
          hazard = m2reg[k-1] && (k < LOAD_LAT);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
// Interlock and forwarding controller for the pipelined MIPS core, sitting
// beside the control unit in ID. A shift-register scoreboard follows the
// destination register of every instruction through NSTAGES stages after ID
// (1 = EXE, 2 = MEM, 3 = WB, ...).
//   clk, rst   clock, asynchronous active-low reset
//   hz         pipe_hazard_unit_if.slave: ID instruction info in,
//              fwd / nostall / scoreboard view out
// Optional build macro HAZ_STATS_EN adds:
//   stall_cnt  saturating count of cycles with nostall = 0
//   fwd_cnt    saturating count of issued cycles using any forward path
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int NSTAGES  = 3,
  parameter int NSRC     = 2,
  parameter int REGAW    = pipe_pkg::REGAW_DEF,
  parameter int LOAD_LAT = 2,
  parameter int FW       = $clog2(NSTAGES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_unit_if.slave    hz
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          fwd_cnt
`endif
);

  import pipe_pkg::*;

  localparam int E1 = STG_EXE - 1;

  logic [NSTAGES-1:0]       wreg_q;
  logic [NSTAGES-1:0]       m2reg_q;
  logic [NSTAGES*REGAW-1:0] rn_q;
  logic [NSRC-1:0]          hazard;
  logic [NSRC*FW-1:0]       fwd_w;
  logic                     nostall_w;
  logic                     advance;

  for (genvar i = 0; i < NSRC; i++) begin : g_match
    pipe_fwd_match #(
      .NSTAGES  (NSTAGES),
      .REGAW    (REGAW),
      .LOAD_LAT (LOAD_LAT),
      .FW       (FW)
    ) u_match (
      .src      (hz.id_src[i*REGAW +: REGAW]),
      .src_used (hz.id_use[i]),
      .wreg     (wreg_q),
      .m2reg    (m2reg_q),
      .rn       (rn_q),
      .fwd      (fwd_w[i*FW +: FW]),
      .hazard   (hazard[i])
    );
  end

  // Flush only decides what enters EXE; it never masks the stall output.
  assign nostall_w = !(hz.id_valid && (|hazard));
  assign advance   = hz.id_valid && nostall_w && !hz.flush;

  // Entry 1 takes the ID instruction or a bubble; older entries just shift.
  // Register 0 is hard-wired, so a write to it is never tracked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_q  <= '0;
      m2reg_q <= '0;
      rn_q    <= '0;
    end else begin
      wreg_q[E1]                  <= advance && hz.id_wreg && (hz.id_rn != '0);
      m2reg_q[E1]                 <= advance && hz.id_m2reg;
      rn_q[E1*REGAW +: REGAW]     <= advance ? hz.id_rn : '0;
      for (int k = 1; k < NSTAGES; k++) begin
        wreg_q[k]                 <= wreg_q[k-1];
        m2reg_q[k]                <= m2reg_q[k-1];
        rn_q[k*REGAW +: REGAW]    <= rn_q[(k-1)*REGAW +: REGAW];
      end
    end
  end

  assign hz.fwd      = fwd_w;
  assign hz.nostall  = nostall_w;
  assign hz.trk_wreg = wreg_q;
  assign hz.trk_rn   = rn_q;

`ifdef HAZ_STATS_EN
  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (!nostall_w && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (hz.id_valid && nostall_w && (|fwd_w) && (fwd_cnt != '1))
        fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised interlock and forwarding controller for the pipelined MIPS core.
- Tracks destination registers of in-flight instructions across NSTAGES post-decode stages in an internal scoreboard shift register.
- Produces per-operand forward selects, a load-use `nostall`, and bubble insertion on flush.
- Sits beside the control unit in ID.
- Generalises the fixed two-operand, EXE/MEM-only `fwda`/`fwdb`/`nostall` logic to arbitrary depth, operand count and load latency.

Parameters:
- NSTAGES, 3, number of tracked stages after ID (1=EXE, 2=MEM, 3=WB).
- NSRC, 2, number of source operands checked per instruction.
- REGAW, 5, register address width.
- LOAD_LAT, 2, first stage index at which load data is forwardable; must be 1..NSTAGES.
- FW, $clog2(NSTAGES+1), derived width of each forward select.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  instruction in ID is valid.
- id_src  in  NSRC*REGAW  source register numbers, operand i at [i*REGAW +: REGAW].
- id_use  in  NSRC  operand i is actually read.
- id_wreg  in  1  ID instruction writes a register.
- id_rn  in  REGAW  ID destination register.
- id_m2reg  in  1  ID instruction is a load.
- flush  in  1  taken branch/jump; kill ID instruction.
- fwd  out  NSRC*FW  per-operand select: 0 = register file, k = result of stage k.
- nostall  out  1  1 = PC and IF/ID may advance.
- trk_wreg  out  NSTAGES  scoreboard write-valid bits, bit k-1 = stage k.
- trk_rn  out  NSTAGES*REGAW  scoreboard destination registers.

Behaviour:
- Scoreboard: NSTAGES entries {wreg, m2reg, rn}. Entry 1 is EXE.
- Every rising clk: entry k <= entry k-1 for k = 2..NSTAGES. Entry 1 loads ID info only when `id_valid & nostall & !flush`; otherwise entry 1 loads a bubble (wreg=0, m2reg=0, rn=0).
- Captured wreg = `id_wreg & (id_rn != 0)`. Register 0 is never tracked.
- Forwarding is combinational from the scoreboard and ID inputs.
  - For operand i: match(k) = `wreg_k & (rn_k == src_i) & (src_i != 0) & id_use[i]`.
  - fwd_i = smallest k with match(k) (youngest producer wins); 0 if none.
- Stall is combinational.
  - Hazard on operand i: youngest match k < LOAD_LAT and m2reg_k = 1.
  - nostall = `!(id_valid & OR of hazards)`.
  - While stalled, fwd still reports the youngest match; the consumer ignores it until nostall = 1.
- Flush and stall in the same cycle: flush wins, a bubble is inserted, and nostall output is unaffected by flush.
- Latency:
  - fwd and nostall: zero cycles from inputs.
  - Scoreboard update: one cycle.
  - A load at entry 1 stalls ID for exactly LOAD_LAT-1 cycles (1 cycle with defaults).
- Reset, asynchronous on rst low: all entries cleared, hence fwd = 0, nostall = 1, trk_wreg = 0, trk_rn = 0. Reset mid-stall drops the stall immediately.
- NSTAGES = 1: only EXE is tracked; fwd is 1 bit.

Optional Feature:
- Macro HAZ_STATS_EN.
- When defined, adds outputs:
  - `stall_cnt` (32, out): counts cycles with nostall = 0.
  - `fwd_cnt` (32, out): counts cycles with `id_valid & nostall` and any fwd_i != 0.
- Both counters saturate at all-ones and reset to 0 asynchronously.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package `pipe_pkg`:
  - Scoreboard entry typedef {wreg, m2reg, rn}.
  - Localparams FWD_RF = 0, STG_EXE = 1, STG_MEM = 2, STG_WB = 3.
  - REGAW default.
- One sub-module, `pipe_fwd_match`: per-operand priority matcher returning fwd select and hazard bit. Instantiated NSRC times via generate.

Test Plan:
- Reset: hold rst=0 with random inputs -> fwd=0, nostall=1, trk_wreg=0. Release rst; idle cycle -> still 0/1.
- EXE/MEM forwarding:
  - add $3 issued (id_wreg=1, id_rn=3), next cycle sub with src0=3, src1=3 -> fwd0=fwd1=1, nostall=1.
  - One cycle later, a third instruction with src1=3 -> fwd1=2.
- Load-use stall: lw $5 issued (id_m2reg=1), next ID src0=5 -> nostall=0 for exactly 1 cycle. Next cycle nostall=1, fwd0=2, trk_wreg=3'b010.
- Youngest wins: $7 written at stages 1 and 3, ID src1=7 -> fwd1=1. Register 0: id_rn=0 with wreg=1 is never tracked, and src=0 -> fwd=0.
- Flush during stall: lw $5 in EXE, dependent in ID, flush=1 -> next cycle entry1 is a bubble (trk_wreg[0]=0). With HAZ_STATS_EN: stall_cnt increments by 1.
- Parameter sweep: NSTAGES=5, LOAD_LAT=3, NSRC=3; load then immediate dependent on operand 2 -> 2 stall cycles, then fwd2=3.
